// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the async-FIFO write-port round-robin arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int NUM_REQ_DEF    = 4;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int MAX_BURST_DEF  = 4;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester at or above last_winner+1, wrapping.
import fifo_arb_pkg::*;

module rr_priority_picker #(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_winner_i,
    output logic [ID_W-1:0]    winner_o,
    output logic               any_req_o
);

    logic [2*NUM_REQ-1:0] dbl;
    logic [2*NUM_REQ-1:0] masked;
    logic                 found;
    int                   start;

    // The upper copy is never masked, so a wrapped search always finds a set bit.
    always_comb begin
        start     = (int'(last_winner_i) >= NUM_REQ - 1) ? 0 : int'(last_winner_i) + 1;
        dbl       = {req_i, req_i};
        masked    = '0;
        winner_o  = '0;
        found     = 1'b0;
        any_req_o = |req_i;
        for (int i = 0; i < 2 * NUM_REQ; i++) begin
            masked[i] = dbl[i] && (i >= start);
        end
        for (int i = 0; i < 2 * NUM_REQ; i++) begin
            if (masked[i] && !found) begin
                found    = 1'b1;
                winner_o = ID_W'(i % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_rr_arbiter.sv
// Burst round-robin arbiter sharing one async-FIFO write port among NUM_REQ streams.
import fifo_arb_pkg::*;

module fifo_wr_rr_arbiter #(
    parameter  int NUM_REQ    = NUM_REQ_DEF,
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter  int MAX_BURST  = MAX_BURST_DEF,
    localparam int ID_W       = id_w(NUM_REQ),
    localparam int CNT_W      = cnt_w(MAX_BURST)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          fifo_we_o,
    output logic [DATA_WIDTH-1:0]         fifo_din_o,
    input  logic                          fifo_wrdy_i,
    output logic                          gnt_valid_o,
    output logic [ID_W-1:0]               gnt_id_o,
    output logic [CNT_W-1:0]              busy_cnt_o
);

    arb_state_e      state_q, state_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    logic [ID_W-1:0]       winner;
    logic                  any_req;
    logic                  in_burst, g_valid, g_last, xfer;
    logic [DATA_WIDTH-1:0] g_data;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_i         (req_valid_i),
        .last_winner_i (last_q),
        .winner_o      (winner),
        .any_req_o     (any_req)
    );

    always_comb begin
        in_burst = (state_q == BURST);
        g_valid  = req_valid_i[gnt_id_q];
        g_last   = req_last_i[gnt_id_q];
        g_data   = req_data_i[gnt_id_q*DATA_WIDTH +: DATA_WIDTH];
        xfer     = in_burst && g_valid && fifo_wrdy_i;
        cnt_inc  = cnt_q + 1'b1;

        req_ready_o = '0;
        if (in_burst) req_ready_o[gnt_id_q] = fifo_wrdy_i;
        fifo_we_o   = xfer;
        fifo_din_o  = in_burst ? g_data : '0;
        gnt_valid_o = in_burst;
        gnt_id_o    = gnt_id_q;
        busy_cnt_o  = cnt_q;
    end

    // The count is kept after a burst ends so the final beat count stays visible.
    always_comb begin
        state_d  = state_q;
        gnt_id_d = gnt_id_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d  = BURST;
                    gnt_id_d = winner;
                    last_d   = winner;
                    cnt_d    = '0;
                end
            end
            BURST: begin
                if (!g_valid) begin
                    state_d = IDLE;
                end else if (fifo_wrdy_i) begin
                    cnt_d = cnt_inc;
                    if (g_last || cnt_inc == CNT_W'(MAX_BURST)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            gnt_id_q <= '0;
            last_q   <= ID_W'(NUM_REQ - 1);
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: doc/fifo_wr_rr_arbiter.md
Name: fifo_wr_rr_arbiter

Overview:
Round-robin burst arbiter that shares the single write port of the async FIFO (write side, clkA domain) between NUM_REQ requesters. Each requester streams words with a valid/ready handshake. The arbiter grants one requester at a time for a burst, muxes its data onto the FIFO write port, and uses the FIFO write-ready to throttle. It sits entirely in the write clock domain, directly in front of the FIFO's we/din/wrdy port.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 8, word width; equals the FIFO DATA_WIDTH
MAX_BURST, 4, maximum words transferred per grant before forced re-arbitration (1..255)

Ports:
clk_i  in  1  write-domain clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  NUM_REQ  per-requester word valid
req_last_i  in  NUM_REQ  per-requester last word of burst, qualified by valid
req_data_i  in  NUM_REQ*DATA_WIDTH  per-requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
req_ready_o  out  NUM_REQ  per-requester ready; at most one bit high
fifo_we_o  out  1  FIFO write enable
fifo_din_o  out  DATA_WIDTH  FIFO write data
fifo_wrdy_i  in  1  FIFO not-full
gnt_valid_o  out  1  a burst grant is active
gnt_id_o  out  $clog2(NUM_REQ)  index of the granted requester
busy_cnt_o  out  $clog2(MAX_BURST+1)  words transferred in the current burst

Behaviour:
- Reset is asynchronous and active-low. Reset values: state=IDLE, gnt_id=0, last_winner=NUM_REQ-1 (requester 0 has first priority), beat count=0. All outputs are 0, including req_ready_o, fifo_we_o, fifo_din_o and gnt_valid_o.
- FSM states: IDLE and BURST.
- IDLE:
  - If any req_valid_i bit is set, pick the first set bit searching upward from last_winner+1 (mod NUM_REQ).
  - On the next edge: register gnt_id, set last_winner to the winner, clear the count, go to BURST.
  - Grant latency: valid sampled in cycle n → ready may assert in cycle n+1.
  - No requests: stay in IDLE; all outputs stay 0.
- BURST, with g = gnt_id:
  - gnt_valid_o=1.
  - req_ready_o[g] = fifo_wrdy_i; all other ready bits are 0.
  - fifo_we_o = req_valid_i[g] & fifo_wrdy_i.
  - fifo_din_o = req_data_i[g] whenever in BURST; 0 in IDLE.
  - Transfer = req_valid_i[g] & fifo_wrdy_i. Each transfer increments the count.
  - End of burst; the state returns to IDLE on the next edge when any of these holds:
    - a transfer with req_last_i[g]=1;
    - a transfer making the count equal MAX_BURST;
    - a cycle with req_valid_i[g]=0 (gap rule).
  - fifo_wrdy_i=0 with valid=1: stall. Hold state and count; the burst does not end.
- Each burst costs one IDLE cycle, so back-to-back bursts are separated by exactly one bubble cycle.
- Fairness: the winner of the last grant has the lowest priority in the next arbitration. With all requesters active, grants go 0,1,2,3,0,...
- Requests that assert while a burst is active are ignored until the next IDLE evaluation.
- The count width holds MAX_BURST; it never wraps inside a burst.
- Reset asserted mid-burst: return immediately to reset values. Data not yet written is the requester's responsibility.
- Requester rule: a requester holding valid with ready=0 must keep data and last stable. The arbiter does not check this.

Decomposition:
- Package fifo_arb_pkg:
  - state enum typedef arb_state_e {IDLE, BURST};
  - localparams for ID width and count width.
- Sub-module rr_priority_picker: purely combinational.
  - Inputs: request vector, last_winner.
  - Outputs: winner index and any_req.
  - Implementation: double-width masked priority encode.
- FSM, count and muxes live in fifo_wr_rr_arbiter.

Test Plan:
1. Reset, then req_valid_i=0001 with last set on the 3rd word, wrdy=1 → gnt_id=0 one cycle later; 3 fifo_we_o pulses with the data in order; back to IDLE; gnt_valid_o drops the cycle after the last word.
2. All 4 requesters valid continuously, last never set, MAX_BURST=4 → grant order 0,1,2,3,0; 4 writes per grant; one idle cycle between grants; busy_cnt_o counts 1..4.
3. Requester 2 granted, wrdy=0 for 5 cycles mid-burst → fifo_we_o=0, req_ready_o=0000, count and gnt_id held; resumes with no lost or duplicated word.
4. Requester 1 granted, valid drops after 2 words → burst ends (count=2); requester 3 (pending) is granted next.
5. Requesters 0 and 3 valid, last_winner=0 → 3 wins; next arbitration with both still valid → 0 wins.
6. rst_ni pulsed low mid-burst → all outputs 0 immediately (asynchronously); after release, requester 0 has priority again.
